mem_access_unit: RTL

Memory-stage access controller for the 5-stage pipeline. It consumes the EX/MEM pipeline register outputs and issues loads and stores to a multi-cycle data memory over a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and drives the MEM/WB-side results: read data, ALU result passthrough, destination register and WB controls.

---
 rtl/mem_access_unit.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access controller for the 5-stage pipeline. Takes the EX/MEM
// pipeline register outputs and issues loads/stores to a multi-cycle data
// memory over a req/ack handshake. The upstream pipeline is stalled while an
// access is outstanding, and the MEM/WB-side registers are driven from here.
//
// Optional feature (compile-time macro MEM_STORE_POST_EN):
//   One-entry posted-write buffer. A store seen in IDLE while the buffer is
//   empty retires immediately; the buffer then owns the memory port until its
//   ack. Without the macro, stores go through ACCESS/DONE exactly like loads.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   MemRead_i,
//   MemWrite_i,
//   RegWrite_i,
//   MemToReg_i          EX/MEM control bits
//   ALUResult_i         memory address (low ADDR_W bits) or ALU result to WB
//   RDData_i            store data
//   RDaddr_i            destination register
//   dmem_req_o          memory request
//   dmem_we_o           1 = write, 0 = read
//   dmem_addr_o         memory byte address
//   dmem_wdata_o        memory write data
//   dmem_ack_i          memory completion, one-cycle pulse
//   dmem_rdata_i        memory read data, valid with dmem_ack_i
//   stall_o             hold PC, IF/ID, ID/EX and EX/MEM
//   RegWrite_o,
//   MemToReg_o          registered WB controls (zeroed while stalled)
//   ReadData_o          registered load data
//   ALUResult_o         registered ALU result
//   RDaddr_o            registered destination register
//
// ADDR_W must not exceed DATA_W (the address is a slice of ALUResult_i).
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] RDData_i,
    input  logic [4:0]        RDaddr_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [4:0]        RDaddr_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic              mem_op;
    logic              acc_latch;
    logic              stall_int;
    logic              port_busy;   // posted store owns the memory port
    logic              post_store;  // store may retire into the posted buffer

    logic              acc_we_reg;
    logic [ADDR_W-1:0] acc_addr_reg;
    logic [DATA_W-1:0] acc_wdata_reg;
    logic [DATA_W-1:0] load_data_reg;

    assign mem_op = MemRead_i | MemWrite_i;

`ifdef MEM_STORE_POST_EN
    // -------------------------------------------------------------------------
    // Posted-write buffer
    // -------------------------------------------------------------------------
    logic              buf_full_reg;
    logic [ADDR_W-1:0] buf_addr_reg;
    logic [DATA_W-1:0] buf_wdata_reg;
    logic              buf_load;

    assign port_busy  = buf_full_reg;
    // A store (including read+write, which counts as a write) retires into the
    // buffer only when the buffer is free.
    assign post_store = MemWrite_i & ~buf_full_reg;
    // Only IDLE evaluates new instructions; ACCESS/DONE always hold a load here.
    assign buf_load   = (state_reg == IDLE) & post_store;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_full_reg  <= 1'b0;
            buf_addr_reg  <= '0;
            buf_wdata_reg <= '0;
        end else begin
            if (buf_full_reg) begin
                if (dmem_ack_i) begin
                    buf_full_reg <= 1'b0;
                end
            end else if (buf_load) begin
                buf_full_reg  <= 1'b1;
                buf_addr_reg  <= ALUResult_i[ADDR_W-1:0];
                buf_wdata_reg <= RDData_i;
            end
        end
    end

    // The buffer and the ACCESS path never own the port at the same time:
    // ACCESS is only entered with the buffer empty, and the buffer is only
    // filled from IDLE.
    always_comb begin
        if (buf_full_reg) begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = 1'b1;
            dmem_addr_o  = buf_addr_reg;
            dmem_wdata_o = buf_wdata_reg;
        end else begin
            dmem_req_o   = (state_reg == ACCESS);
            dmem_we_o    = acc_we_reg;
            dmem_addr_o  = acc_addr_reg;
            dmem_wdata_o = acc_wdata_reg;
        end
    end
`else
    assign port_busy    = 1'b0;
    assign post_store   = 1'b0;

    // Request is decoded straight from the state register, so the async reset
    // of that register drops it without waiting for a clock edge.
    assign dmem_req_o   = (state_reg == ACCESS);
    assign dmem_we_o    = acc_we_reg;
    assign dmem_addr_o  = acc_addr_reg;
    assign dmem_wdata_o = acc_wdata_reg;
`endif

    // -------------------------------------------------------------------------
    // FSM: next state and stall
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        acc_latch  = 1'b0;
        stall_int  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (port_busy) begin
                    // Any memory instruction waits out the posted store,
                    // including its ack cycle; it is re-evaluated next cycle.
                    stall_int = mem_op;
                end else if (mem_op && !post_store) begin
                    stall_int  = 1'b1;
                    acc_latch  = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                stall_int = 1'b1;
                if (dmem_ack_i) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Held low during reset so every output reads 0 while rst_i is asserted.
    assign stall_o = stall_int & rst_i;

    // -------------------------------------------------------------------------
    // State register, access latches and load-data capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            acc_we_reg    <= 1'b0;
            acc_addr_reg  <= '0;
            acc_wdata_reg <= '0;
            load_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (acc_latch) begin
                // Read+write together is treated as a write.
                acc_we_reg    <= MemWrite_i;
                acc_addr_reg  <= ALUResult_i[ADDR_W-1:0];
                acc_wdata_reg <= RDData_i;
            end
            if ((state_reg == ACCESS) && dmem_ack_i) begin
                load_data_reg <= dmem_rdata_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // MEM/WB output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
            ReadData_o  <= '0;
            ALUResult_o <= '0;
            RDaddr_o    <= '0;
        end else if (stall_o) begin
            // Bubble into WB: kill the write-back controls, hold the data.
            RegWrite_o <= 1'b0;
            MemToReg_o <= 1'b0;
        end else begin
            RegWrite_o  <= RegWrite_i;
            MemToReg_o  <= MemToReg_i;
            ALUResult_o <= ALUResult_i;
            RDaddr_o    <= RDaddr_i;
            if (state_reg == DONE) begin
                ReadData_o <= load_data_reg;
            end
        end
    end

endmodule
